// File: rtl/ad7606c_spi_master.sv
// rtl/ad7606c_spi_master.sv - SPI master for AD7606C 8-channel readout and 16-bit register writes
//
// Ports:
//   i_clk, i_rst           system clock, synchronous active-low reset
//   i_adc_spi_start        1-cycle pulse, start 8 ch x 16 bit read over 4 DOUT lines
//   o_adc_spi_done         1-cycle pulse, read finished; o_ch_data updated in the same cycle
//   i_init_spi_start       1-cycle pulse, start 16-bit register write on SDI
//   o_init_spi_done        1-cycle pulse, register write finished
//   i_cpol, i_cpha         SPI mode, latched at transaction start
//   i_init_data            register word, MSB first, latched at start
//   o_spi_cs_n, o_spi_sclk, o_spi_sdi, i_spi_dout   ADC pins (i_spi_dout[0] = DOUTA)
//   o_ch_data              ch k at [16k+15:16k]
//   o_busy                 high from start accept through the done pulse
module ad7606c_spi_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_adc_spi_start,
  output logic         o_adc_spi_done,
  input  logic         i_init_spi_start,
  output logic         o_init_spi_done,
  input  logic         i_cpol,
  input  logic         i_cpha,
  input  logic [15:0]  i_init_data,
  output logic         o_spi_cs_n,
  output logic         o_spi_sclk,
  output logic         o_spi_sdi,
  input  logic [3:0]   i_spi_dout,
  output logic [127:0] o_ch_data,
  output logic         o_busy
);

  localparam int MAXP = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                             : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CW = (MAXP < 2) ? 1 : $clog2(MAXP);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           half, half_d;          // 0: leading half of bit, 1: trailing half
  logic [5:0]     bits_left, bits_left_d;
  logic           lead_ev, trail_ev;     // this edge of i_clk produces an SCLK edge
  logic           start_init, start_read;
  logic           sample_ev, shift_ev;

  logic           cpol_q, cpha_q, init_q;
  logic [15:0]    sh_sdi;
  logic [3:0][31:0] rx;
  logic [127:0]   ch_data;
  logic           sclk_q, sdi_q, cs_n_q;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    half_d      = half;
    bits_left_d = bits_left;
    lead_ev     = 1'b0;
    trail_ev    = 1'b0;
    start_init  = 1'b0;
    start_read  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d  = '0;
        half_d = 1'b0;
        // init has priority when both starts arrive together
        if (i_init_spi_start) begin
          start_init  = 1'b1;
          bits_left_d = 6'd16;
          state_d     = SETUP;
        end else if (i_adc_spi_start) begin
          start_read  = 1'b1;
          bits_left_d = 6'd32;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_d   = '0;
          half_d  = 1'b0;
          lead_ev = 1'b1;               // first leading edge coincides with entering SHIFT
          state_d = SHIFT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          if (!half) begin
            half_d   = 1'b1;
            trail_ev = 1'b1;
          end else begin
            half_d      = 1'b0;
            bits_left_d = bits_left - 6'd1;
            if (bits_left == 6'd1) state_d = HOLD;
            else                   lead_ev = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sample_ev = cpha_q ? trail_ev : lead_ev;
  assign shift_ev  = cpha_q ? lead_ev  : trail_ev;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      half      <= 1'b0;
      bits_left <= '0;
      cpol_q    <= 1'b1;
      cpha_q    <= 1'b0;
      init_q    <= 1'b0;
      sh_sdi    <= '0;
      rx        <= '0;
      ch_data   <= '0;
      sclk_q    <= 1'b1;
      sdi_q     <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      half      <= half_d;
      bits_left <= bits_left_d;
      cs_n_q    <= !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);

      if (start_init || start_read) begin
        cpol_q <= i_cpol;
        cpha_q <= i_cpha;
        init_q <= start_init;
        sclk_q <= i_cpol;
        rx     <= '0;
        if (start_init && !i_cpha) begin
          // CPHA=0: the slave samples on the first edge, so bit 15 goes out with CS
          sdi_q  <= i_init_data[15];
          sh_sdi <= {i_init_data[14:0], 1'b0};
        end else if (start_init) begin
          sdi_q  <= 1'b0;
          sh_sdi <= i_init_data;
        end else begin
          sdi_q  <= 1'b0;
          sh_sdi <= '0;
        end
      end else if (state == IDLE) begin
        sclk_q <= i_cpol;
      end

      if (lead_ev)  sclk_q <= ~cpol_q;
      if (trail_ev) sclk_q <= cpol_q;

      if (shift_ev) begin
        sdi_q  <= sh_sdi[15];
        sh_sdi <= {sh_sdi[14:0], 1'b0};
      end

      if (sample_ev && !init_q) begin
        for (int l = 0; l < 4; l++) rx[l] <= {rx[l][30:0], i_spi_dout[l]};
      end

      if (state == HOLD && state_d == DONE) begin
        sdi_q <= 1'b0;
        if (!init_q) begin
          // each line carries its even channel first, then the odd one
          for (int l = 0; l < 4; l++) begin
            ch_data[32*l +: 16]      <= rx[l][31:16];
            ch_data[32*l + 16 +: 16] <= rx[l][15:0];
          end
        end
      end
    end
  end

  assign o_spi_cs_n      = cs_n_q;
  assign o_spi_sclk      = sclk_q;
  assign o_spi_sdi       = sdi_q;
  assign o_ch_data       = ch_data;
  assign o_busy          = (state != IDLE);
  assign o_adc_spi_done  = (state == DONE) && !init_q;
  assign o_init_spi_done = (state == DONE) && init_q;

endmodule

// File: tb/tb_ad7606c_spi_master.sv
// tb/tb_ad7606c_spi_master.sv - directed self-checking bench for ad7606c_spi_master
module tb_ad7606c_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, adc_start, init_start, cpol, cpha;
  logic [15:0]  init_data;
  logic [3:0]   dout = 4'h0;
  logic         adc_done, init_done, cs_n, sclk, sdi, busy;
  logic [127:0] ch_data;

  logic         b_start, c_start;
  logic         zero1 = 1'b0;
  logic [3:0]   zero4 = 4'h0;
  logic         b_adc_done, b_init_done, b_cs_n, b_sclk, b_sdi, b_busy;
  logic         c_adc_done, c_init_done, c_cs_n, c_sclk, c_sdi, c_busy;
  logic [127:0] b_ch_data, c_ch_data;

  ad7606c_spi_master dut (
    .i_clk(clk), .i_rst(rst), .i_adc_spi_start(adc_start), .o_adc_spi_done(adc_done),
    .i_init_spi_start(init_start), .o_init_spi_done(init_done), .i_cpol(cpol), .i_cpha(cpha),
    .i_init_data(init_data), .o_spi_cs_n(cs_n), .o_spi_sclk(sclk), .o_spi_sdi(sdi),
    .i_spi_dout(dout), .o_ch_data(ch_data), .o_busy(busy));

  ad7606c_spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_adc_spi_start(zero1), .o_adc_spi_done(b_adc_done),
    .i_init_spi_start(b_start), .o_init_spi_done(b_init_done), .i_cpol(cpol), .i_cpha(cpha),
    .i_init_data(init_data), .o_spi_cs_n(b_cs_n), .o_spi_sclk(b_sclk), .o_spi_sdi(b_sdi),
    .i_spi_dout(zero4), .o_ch_data(b_ch_data), .o_busy(b_busy));

  ad7606c_spi_master #(.CLK_DIV(5), .CS_SETUP(3), .CS_HOLD(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_adc_spi_start(zero1), .o_adc_spi_done(c_adc_done),
    .i_init_spi_start(c_start), .o_init_spi_done(c_init_done), .i_cpol(cpol), .i_cpha(cpha),
    .i_init_data(init_data), .o_spi_cs_n(c_cs_n), .o_spi_sclk(c_sclk), .o_spi_sdi(c_sdi),
    .i_spi_dout(zero4), .o_ch_data(c_ch_data), .o_busy(c_busy));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ADC model: line l shifts out {ch[2l], ch[2l+1]} MSB first
  logic [15:0] ch [8];
  logic        m_cpol, m_cpha;
  int          ptr;

  task automatic drive(input int b);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) begin
      w = {ch[2*l], ch[2*l+1]};
      dout[l] = w[b];
    end
  endtask

  always @(negedge cs_n) begin
    m_cpol = cpol;
    m_cpha = cpha;
    if (!m_cpha) begin
      drive(31);
      ptr = 30;
    end else begin
      ptr = 31;
    end
  end

  always @(sclk) begin
    if (cs_n === 1'b0) begin
      if (((sclk != m_cpol) && m_cpha) || ((sclk == m_cpol) && !m_cpha)) begin
        if (ptr >= 0) begin
          drive(ptr);
          ptr--;
        end
      end
    end
  end

  // pin watchers
  int          rise_cnt = 0, fall_cnt = 0, sdi_hi = 0, adc_done_cnt = 0;
  logic [15:0] sdi_word = 16'h0;

  always @(posedge sclk) if (cs_n === 1'b0) rise_cnt++;
  always @(negedge sclk) if (cs_n === 1'b0) begin
    fall_cnt++;
    sdi_word = {sdi_word[14:0], sdi};
  end
  always @(posedge clk) begin
    if (cs_n === 1'b0 && sdi === 1'b1) sdi_hi++;
    if (adc_done === 1'b1) adc_done_cnt++;
  end

  function automatic logic sclk_of(input int which);
    return (which == 1) ? b_sclk : c_sclk;
  endfunction

  function automatic logic done_of(input int which);
    return (which == 1) ? b_init_done : c_init_done;
  endfunction

  task automatic sweep(input string tag, input int which, input int exp_first,
                       input int exp_half, input int exp_done);
    int  n, e1, e2;
    logic prev, cur;
    if (which == 1) b_start = 1'b1; else c_start = 1'b1;
    step();
    b_start = 1'b0;
    c_start = 1'b0;
    n = 1; e1 = -1; e2 = -1; prev = cpol;
    while (!done_of(which) && n < 400) begin
      cur = sclk_of(which);
      if (cur != prev) begin
        if (e1 < 0) e1 = n;
        else if (e2 < 0) e2 = n;
      end
      prev = cur;
      step();
      n++;
    end
    check({tag, "_first_edge"}, e1, exp_first);
    check({tag, "_half_period"}, e2 - e1, exp_half);
    check({tag, "_done_cycle"}, n, exp_done);
  endtask

  logic [127:0] exp_ch;
  int           n;

  initial begin
    rst = 1'b0; adc_start = 1'b0; init_start = 1'b0; cpol = 1'b1; cpha = 1'b0;
    init_data = 16'h0; b_start = 1'b0; c_start = 1'b0;
    ch[0] = 16'h8001; ch[1] = 16'h7FFE; ch[2] = 16'h1234; ch[3] = 16'hABCD;
    ch[4] = 16'h0000; ch[5] = 16'hFFFF; ch[6] = 16'h5A5A; ch[7] = 16'hA5A5;
    for (int k = 0; k < 8; k++) exp_ch[16*k +: 16] = ch[k];

    repeat (3) step();
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_sdi", sdi, 1'b0);
    check("rst_adc_done", adc_done, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ch_data", ch_data, 128'h0);
    rst = 1'b1;
    step();

    // 1: reset in the middle of a read
    cpol = 1'b1; cpha = 1'b1;
    adc_start = 1'b1;
    step();
    adc_start = 1'b0;
    check("t1_cs_fall_cycle1", cs_n, 1'b0);
    repeat (39) step();
    rst = 1'b0;
    adc_done_cnt = 0;
    step();
    rst = 1'b1;
    check("t1_abort_cs_n", cs_n, 1'b1);
    check("t1_abort_sclk", sclk, 1'b1);
    check("t1_abort_busy", busy, 1'b0);
    check("t1_abort_ch_data", ch_data, 128'h0);
    repeat (150) step();
    check("t1_no_done", adc_done_cnt, 0);

    // 2: full read, cpol=1 cpha=1
    rise_cnt = 0; sdi_hi = 0;
    adc_start = 1'b1;
    step();
    adc_start = 1'b0;
    n = 1;
    while (!adc_done && n < 400) begin step(); n++; end
    check("t2_done_cycle", n, 133);
    for (int k = 0; k < 8; k++) check($sformatf("t2_ch%0d", k), ch_data[16*k +: 16], ch[k]);
    check("t2_rising_edges", rise_cnt, 32);
    check("t2_sdi_zero", sdi_hi, 0);
    check("t2_busy_at_done", busy, 1'b1);
    check("t2_cs_n_at_done", cs_n, 1'b1);
    step();
    check("t2_done_one_cycle", adc_done, 1'b0);
    check("t2_idle_after_done", busy, 1'b0);

    // 3: init write started the cycle after done, cpol=1 cpha=0
    cpha = 1'b0; init_data = 16'h0218; fall_cnt = 0; adc_done_cnt = 0;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    n = 1;
    while (!init_done && n < 400) begin step(); n++; end
    check("t3_done_cycle", n, 69);
    check("t3_sdi_word", sdi_word, 16'h0218);
    check("t3_fall_edges", fall_cnt, 16);
    check("t3_ch_data_kept", ch_data, exp_ch);
    check("t3_no_adc_done", adc_done_cnt, 0);

    // 5: simultaneous starts, then a read start while busy
    step();
    init_data = 16'hC3A5; fall_cnt = 0; adc_done_cnt = 0;
    init_start = 1'b1; adc_start = 1'b1;
    step();
    init_start = 1'b0; adc_start = 1'b0;
    n = 1;
    while (!init_done && n < 400) begin
      adc_start = (n == 10);
      step();
      n++;
    end
    adc_start = 1'b0;
    check("t5_init_done_cycle", n, 69);
    check("t5_sdi_word", sdi_word, 16'hC3A5);
    repeat (140) step();
    check("t5_no_adc_done", adc_done_cnt, 0);
    check("t5_idle", busy, 1'b0);

    // 6: inputs toggled mid-transfer, cpol=0 cpha=1 latched
    cpol = 1'b0; cpha = 1'b1; init_data = 16'h9C3B; fall_cnt = 0;
    step();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    n = 1;
    while (!init_done && n < 400) begin
      if (n == 5) begin init_data = ~init_data; cpha = 1'b0; end
      step();
      n++;
    end
    check("t6_done_cycle", n, 69);
    check("t6_sdi_word", sdi_word, 16'h9C3B);
    check("t6_fall_edges", fall_cnt, 16);

    // 4: timing sweep over other parameter sets
    cpol = 1'b1; cpha = 1'b0;
    step();
    sweep("t4_div1_s1_h3", 1, 2, 1, 37);
    step();
    sweep("t4_div5_s3_h1", 2, 4, 5, 165);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
